// File: rtl/membuf_nch.sv
// Load/store buffer: up to CH ops per cycle are queued in program order in a
// DEPTH-entry ring and issued one at a time on the dmem request/response bus.
module membuf_nch #(
    parameter int XLEN   = 32,
    parameter int CH     = 3,
    parameter int DEPTH  = 8,
    parameter int PARA_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        mem_vld,
    input  logic [CH*PARA_W-1:0] mem_para,
    input  logic [CH*XLEN-1:0]   mem_addr,
    input  logic [CH*XLEN-1:0]   mem_wdata,
    output logic                 mem_release,
    output logic [4:0]           mem_sel,
    output logic [XLEN-1:0]      mem_data,
    output logic                 ovf_err,
    output logic                 dmem_req,
    output logic                 dmem_cmd,
    output logic [1:0]           dmem_width,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic [XLEN-1:0]      dmem_rdata,
    input  logic                 dmem_resp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CH_C    = CNT_W'(CH);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [PARA_W-1:0] r_para  [DEPTH];
    logic [XLEN-1:0]   r_addr  [DEPTH];
    logic [XLEN-1:0]   r_wdata [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_release, r_ovf;
    logic [4:0]       r_sel;
    logic [XLEN-1:0]  r_data;

    logic [CNT_W-1:0] w_free, w_n_push, w_count_nxt;
    logic [CH-1:0]    w_lane_acc;
    logic [PTR_W-1:0] w_lane_idx [CH];
    logic             w_drop, w_pop;

    logic [PARA_W-1:0] w_head_para;
    logic [XLEN-1:0]   w_head_addr, w_head_wdata;
    logic              w_head_cmd, w_head_sign;
    logic [1:0]        w_head_width;
    logic [4:0]        w_head_rd;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [XLEN-1:0]   w_ld_data;

    // Space is judged against the count at cycle start, so a same-cycle pop
    // never makes room for a push; lower lanes claim the free slots first.
    // NOTE: every always_comb output gets a default up front so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_free     = DEPTH_C - r_count;
        w_n_push   = '0;
        w_drop     = 1'b0;
        w_lane_acc = '0;
        for (int i = 0; i < CH; i++) begin
            w_lane_idx[i] = r_wr_ptr + w_n_push[PTR_W-1:0];
            if (mem_vld[i]) begin
                if (w_n_push < w_free) begin
                    w_lane_acc[i] = 1'b1;
                    w_n_push      = w_n_push + CNT_W'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    assign w_pop       = (r_state == S_ISSUE) && dmem_resp;
    assign w_count_nxt = r_count + w_n_push - {{(CNT_W-1){1'b0}}, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_count_nxt != '0) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
        endcase
    end

    assign w_head_para  = r_para[r_rd_ptr];
    assign w_head_addr  = r_addr[r_rd_ptr];
    assign w_head_wdata = r_wdata[r_rd_ptr];
    assign w_head_sign  = w_head_para[8];
    assign w_head_width = w_head_para[7:6];
    assign w_head_cmd   = w_head_para[5];
    assign w_head_rd    = w_head_para[4:0];

    always_comb begin
        dmem_req   = 1'b0;
        dmem_cmd   = 1'b0;
        dmem_width = 2'd0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (r_state == S_ISSUE) begin
            dmem_req   = 1'b1;
            dmem_cmd   = w_head_cmd;
            dmem_width = w_head_width;
            dmem_addr  = w_head_addr;
            case (w_head_width)
                2'd0:    dmem_wdata = {(XLEN/8){w_head_wdata[7:0]}};
                2'd1:    dmem_wdata = {(XLEN/16){w_head_wdata[15:0]}};
                default: dmem_wdata = w_head_wdata;
            endcase
        end
    end

    always_comb begin
        w_ld_byte = dmem_rdata[{w_head_addr[1:0], 3'b000} +: 8];
        w_ld_half = w_head_addr[1] ? dmem_rdata[16 +: 16] : dmem_rdata[0 +: 16];
        case (w_head_width)
            2'd0:    w_ld_data = {{(XLEN-8){w_head_sign & w_ld_byte[7]}}, w_ld_byte};
            2'd1:    w_ld_data = {{(XLEN-16){w_head_sign & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_release <= 1'b1;
            r_ovf     <= 1'b0;
            r_sel     <= '0;
            r_data    <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + w_n_push[PTR_W-1:0];
            r_count   <= w_count_nxt;
            r_release <= (DEPTH_C - w_count_nxt) >= CH_C;
            r_sel     <= '0;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_drop) r_ovf <= 1'b1;
            if (w_pop && !w_head_cmd && (w_head_rd != 5'd0)) begin
                r_sel  <= w_head_rd;
                r_data <= w_ld_data;
            end
        end
    end

    // NOTE: the entry storage has no reset; an entry is only read after a push
    // has written it, and the empty count already marks stale slots invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (w_lane_acc[i]) begin
                r_para[w_lane_idx[i]]  <= mem_para[i*PARA_W +: PARA_W];
                r_addr[w_lane_idx[i]]  <= mem_addr[i*XLEN +: XLEN];
                r_wdata[w_lane_idx[i]] <= mem_wdata[i*XLEN +: XLEN];
            end
        end
    end

    assign mem_release = r_release;
    assign mem_sel     = r_sel;
    assign mem_data    = r_data;
    assign ovf_err     = r_ovf;

endmodule

// File: tb/tb_membuf_nch.sv
// Directed bench for membuf_nch: expected dmem requests are queued as ops are
// pushed and checked in order as the buffer issues them.
module tb_membuf_nch;

    localparam int XLEN = 32;
    localparam int CH   = 3;
    localparam int PW   = 9;

    typedef struct {
        logic        cmd;
        logic [1:0]  w;
        logic        sgn;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] raw;
        logic [31:0] wdata;
    } op_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH-1:0]        mem_vld;
    logic [CH*PW-1:0]     mem_para;
    logic [CH*XLEN-1:0]   mem_addr, mem_wdata;
    logic                 mem_release, ovf_err;
    logic [4:0]           mem_sel;
    logic [XLEN-1:0]      mem_data;
    logic                 dmem_req, dmem_cmd, dmem_resp;
    logic [1:0]           dmem_width;
    logic [XLEN-1:0]      dmem_addr, dmem_wdata, dmem_rdata;

    int  n_vec = 0;
    int  n_err = 0;
    op_t req_q[$];

    membuf_nch #(.XLEN(XLEN), .CH(CH), .DEPTH(8), .PARA_W(PW)) dut (
        .clk(clk), .rst(rst),
        .mem_vld(mem_vld), .mem_para(mem_para), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_release(mem_release), .mem_sel(mem_sel), .mem_data(mem_data), .ovf_err(ovf_err),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [31:0] st_model(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ld_model(input logic [1:0] w, input logic sgn,
                                             input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * addr[1:0])) & 32'h0000_00FF;
        h = (rd >> (16 * addr[1])) & 32'h0000_FFFF;
        case (w)
            2'd0:    return (sgn && b[7])  ? (b | 32'hFFFF_FF00) : b;
            2'd1:    return (sgn && h[15]) ? (h | 32'hFFFF_0000) : h;
            default: return rd;
        endcase
    endfunction

    function automatic op_t mk_op(input logic cmd, input logic [1:0] w, input logic sgn,
                                  input logic [4:0] rd, input logic [31:0] addr,
                                  input logic [31:0] raw);
        op_t o;
        o.cmd = cmd; o.w = w; o.sgn = sgn; o.rd = rd; o.addr = addr; o.raw = raw;
        o.wdata = st_model(w, raw);
        return o;
    endfunction

    task automatic put_lane(input int ln, input op_t o, input bit accept);
        mem_vld[ln]              = 1'b1;
        mem_para[ln*PW +: PW]    = {o.sgn, o.w, o.cmd, o.rd};
        mem_addr[ln*XLEN +: XLEN]  = o.addr;
        mem_wdata[ln*XLEN +: XLEN] = o.raw;
        if (accept) req_q.push_back(o);
    endtask

    task automatic clear_lanes;
        mem_vld   = '0;
        mem_para  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic do_reset;
        clear_lanes();
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req_q.delete();
    endtask

    // Waits for a request, holds it dly cycles, checks it against the scoreboard,
    // completes it with rdata and checks the writeback on the following cycle.
    task automatic serve(input int dly, input logic [31:0] rdata);
        op_t         e;
        logic [4:0]  exp_sel;
        logic [31:0] exp_dat;
        for (int k = 0; k < 64 && dmem_req !== 1'b1; k++) tick();
        check("req_wait", dmem_req, 1'b1);
        for (int k = 0; k < dly; k++) begin
            check("req_hold", dmem_req, 1'b1);
            tick();
        end
        e = req_q.pop_front();
        check("req_cmd", dmem_cmd, e.cmd);
        check("req_width", dmem_width, e.w);
        check("req_addr", dmem_addr, e.addr);
        check("req_wdata", dmem_wdata, e.wdata);
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_resp = 1'b0;
        exp_sel = '0;
        exp_dat = '0;
        if (!e.cmd && e.rd != 5'd0) begin
            exp_sel = e.rd;
            exp_dat = ld_model(e.w, e.sgn, e.addr, rdata);
        end
        check("wb_sel", mem_sel, exp_sel);
        if (exp_sel != 5'd0) check("wb_data", mem_data, exp_dat);
    endtask

    initial begin
        op_t         o, e;
        int          k, sent, done;
        bit          pend_v, started;
        logic [4:0]  pend_sel;
        logic [31:0] pend_dat;

        rst = 1'b1;
        clear_lanes();
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        tick();
        check("rst_release", mem_release, 1'b1);
        check("rst_req", dmem_req, 1'b0);
        check("rst_sel", mem_sel, 5'd0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_addr", dmem_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Single word load; request must rise the cycle after the push.
        put_lane(0, mk_op(1'b0, 2'd2, 1'b0, 5'd5, 32'h0000_0100, 32'h0), 1'b1);
        check("lw_req_before", dmem_req, 1'b0);
        tick();
        clear_lanes();
        check("lw_req_latency", dmem_req, 1'b1);
        serve(1, 32'hDEAD_BEEF);
        check("lw_data_exact", mem_data, 32'hDEAD_BEEF);
        tick();
        check("lw_sel_one_cycle", mem_sel, 5'd0);
        check("lw_idle", dmem_req, 1'b0);

        // Three lanes in one cycle: program order SB, LB (signed), LHU.
        put_lane(0, mk_op(1'b1, 2'd0, 1'b0, 5'd0, 32'h0000_0020, 32'h1234_56AB), 1'b1);
        put_lane(1, mk_op(1'b0, 2'd0, 1'b1, 5'd3, 32'h0000_0021, 32'h0), 1'b1);
        put_lane(2, mk_op(1'b0, 2'd1, 1'b0, 5'd4, 32'h0000_0022, 32'h0), 1'b1);
        tick();
        clear_lanes();
        check("sb_wdata_rep", dmem_wdata, 32'hABAB_ABAB);
        serve(1, 32'h0);
        serve(0, 32'h0000_8000);
        check("lb_sext", mem_data, 32'hFFFF_FF80);
        serve(1, 32'h80FF_7F00);
        check("lhu_zext", mem_data, 32'h0000_80FF);

        // Fill with response held low, then overflow: lane 2 dropped, then all.
        for (int g = 0; g < 3; g++) begin
            for (int ln = 0; ln < CH; ln++) begin
                k = g * CH + ln;
                o = mk_op(k[0], 2'(k % 3), k[1], 5'(k + 8), 32'h200 + 4 * k + (k % 4),
                          32'hC0DE_0000 + k * 32'h111);
                put_lane(ln, o, k < 8);
            end
            tick();
            clear_lanes();
            if (g == 0) begin
                check("fill_rel_hi", mem_release, 1'b1);
                check("fill_ovf_lo", ovf_err, 1'b0);
            end else if (g == 1) begin
                check("fill_rel_lo", mem_release, 1'b0);
                check("fill_ovf_lo2", ovf_err, 1'b0);
            end else begin
                check("fill_ovf_partial", ovf_err, 1'b1);
            end
        end
        for (int ln = 0; ln < CH; ln++)
            put_lane(ln, mk_op(1'b1, 2'd2, 1'b0, 5'd1, 32'h3F0 + 4 * ln, 32'hBAD0_0000), 1'b0);
        tick();
        clear_lanes();
        check("full_ovf", ovf_err, 1'b1);
        check("full_rel", mem_release, 1'b0);
        for (int n = 0; n < 8; n++) serve(n % 2, 32'h8899_AAB0 + n * 32'h0101_0107);
        for (int n = 0; n < 3; n++) begin
            check("full_no_extra_req", dmem_req, 1'b0);
            tick();
        end
        check("drain_rel", mem_release, 1'b1);

        // Streaming with response tied high, pushing only when release is set.
        do_reset();
        dmem_resp = 1'b1;
        sent = 0; done = 0; pend_v = 1'b0; started = 1'b0;
        pend_sel = '0; pend_dat = '0;
        check("st_rel0", mem_release, 1'b1);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (sent == 4 && req_q.size() == 0 && !pend_v) break;
            check("st_sel", mem_sel, pend_v ? pend_sel : 5'd0);
            if (pend_v) check("st_data", mem_data, pend_dat);
            pend_v = 1'b0;
            if (started && req_q.size() > 0) check("st_req", dmem_req, 1'b1);
            dmem_rdata = 32'h5A00_0000 + cyc * 32'h0001_0283;
            if (dmem_req) begin
                started = 1'b1;
                e = req_q.pop_front();
                check("st_addr", dmem_addr, e.addr);
                check("st_width", dmem_width, e.w);
                done++;
                pend_v   = 1'b1;
                pend_sel = e.rd;
                pend_dat = ld_model(e.w, e.sgn, e.addr, dmem_rdata);
            end
            if (sent < 4 && mem_release) begin
                for (int ln = 0; ln < CH; ln++) begin
                    k = sent * CH + ln;
                    o = mk_op(1'b0, 2'(ln), sent[0], 5'(k + 1),
                              32'h1000 + 4 * k + ((ln == 0) ? (k % 4) : (ln == 1) ? 2 * (k % 2) : 0),
                              32'h0);
                    put_lane(ln, o, 1'b1);
                end
                sent++;
            end
            tick();
            clear_lanes();
        end
        check("st_done", done, 12);
        check("st_no_ovf", ovf_err, 1'b0);
        check("st_idle", dmem_req, 1'b0);

        // Reset while issuing with 4 entries queued.
        dmem_resp = 1'b0;
        for (int ln = 0; ln < CH; ln++)
            put_lane(ln, mk_op(1'b0, 2'd2, 1'b0, 5'(20 + ln), 32'h500 + 4 * ln, 32'h0), 1'b1);
        tick();
        clear_lanes();
        put_lane(0, mk_op(1'b0, 2'd2, 1'b0, 5'd23, 32'h50C, 32'h0), 1'b1);
        tick();
        clear_lanes();
        check("mid_req", dmem_req, 1'b1);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        rst = 1'b1;
        #1;
        check("mid_rst_req", dmem_req, 1'b0);
        check("mid_rst_addr", dmem_addr, 32'h0);
        check("mid_rst_rel", mem_release, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        req_q.delete();
        for (int n = 0; n < 4; n++) begin
            check("post_rst_sel", mem_sel, 5'd0);
            check("post_rst_req", dmem_req, 1'b0);
            tick();
        end
        dmem_resp = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
